// File: rtl/keypad_scanner_if.sv
// Keypad pin-side and key-code-side signals of keypad_scanner.
// master: the scanner (drives columns and key outputs, reads rows).
// slave : the board/consumer side (drives rows, reads everything else).
interface keypad_scanner_if;
  logic [3:0] row;        // active-low rows, asynchronous to clk
  logic [3:0] col;        // active-low columns, one low at a time
  logic [3:0] key;        // {row_idx, col_idx} of the debounced key
  logic       key_valid;  // high while a debounced key is held
  logic       key_press;  // one-cycle strobe on each accepted press

  modport master (
    input  row,
    output col, key, key_valid, key_press
  );

  modport slave (
    output row,
    input  col, key, key_valid, key_press
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with row synchroniser, ghost rejection and a
// per-scan debounce FSM. Emits the debounced key code, a held-level valid
// and a one-cycle press strobe.
// Optional: define KEYPAD_AUTOREPEAT_EN to re-pulse key_press while a key
// stays held (first after REPEAT_DELAY_SCANS, then every REPEAT_RATE_SCANS).
module keypad_scanner #(
  parameter int SCAN_DIV       = 4000,  // clocks per column step, >= 4
  parameter int DEBOUNCE_SCANS = 16     // identical scans to accept, >= 2
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY_SCANS = 200
  , parameter int REPEAT_RATE_SCANS  = 40
`endif
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAXV = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                            REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int REP_W = $clog2(REP_MAXV + 1);
  localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY_SCANS);
  localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE_SCANS);
  localparam logic [REP_W-1:0] REP_SAT   = REP_W'(REP_MAXV);
`endif

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_e;

  // ---------------------------------------------------------------------
  // Row synchroniser
  // ---------------------------------------------------------------------
  logic [3:0] row_meta_q, row_sync_q;

  // Two-flop synchroniser; idle (all released) rows read as ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      // NOTE: non-blocking so the second stage takes the first stage's
      // pre-edge value; blocking here would collapse the two flops into one.
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Column divider and scan accumulation
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             sample, scan_done;

  // Step the divider; the last count of each column is the sample point.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    scan_done = sample && (col_idx_q == 2'd3);
    div_d     = sample ? '0 : div_q + DIV_W'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
  end

  logic [3:0] row_hits;
  logic [2:0] hit_num;
  logic [1:0] row_idx;
  logic [1:0] base_cnt, acc_cnt_q, acc_cnt_d;
  logic [3:0] base_code, acc_code_q, acc_code_d;
  logic [2:0] sum_cnt;
  scan_e      scan_kind;

  // Fold this column's rows into the running count/code of the scan.
  always_comb begin
    // NOTE: every variable gets a value before any conditional logic, so
    // no path through this block can leave one unassigned (no latch).
    row_hits = ~row_sync_q;
    hit_num  = 3'(row_hits[0]) + 3'(row_hits[1]) +
               3'(row_hits[2]) + 3'(row_hits[3]);
    row_idx  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_hits[r]) row_idx = 2'(r);
    end
    // Column 0 starts a fresh scan.
    base_cnt   = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
    base_code  = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
    sum_cnt    = {1'b0, base_cnt} + hit_num;
    acc_cnt_d  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    acc_code_d = (base_cnt == 2'd0 && hit_num == 3'd1) ?
                 {row_idx, col_idx_q} : base_code;
    scan_kind  = SCAN_NONE;
    if (acc_cnt_d == 2'd1)      scan_kind = SCAN_SINGLE;
    else if (acc_cnt_d == 2'd2) scan_kind = SCAN_MULTI;
  end

  // Divider, column index and scan accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      if (sample) begin
        acc_cnt_q  <= acc_cnt_d;
        acc_code_q <= acc_code_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Debounce FSM, advanced once per completed scan
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_press_q, key_press_d;
  logic             single, match;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_first_q, rep_first_d;
`endif

  // Next state and outputs; MULTI scans count as NONE (no ghost decode).
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    key_press_d = 1'b0;
    single      = (scan_kind == SCAN_SINGLE);
    match       = single && (acc_code_d == cand_q);
    cnt_inc     = (cnt_q == DEB_LAST) ? cnt_q : cnt_q + DEB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_inc     = (rep_cnt_q == REP_SAT) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
`endif
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (single) begin
            state_d = CONFIRM;
            cand_d  = acc_code_d;
            cnt_d   = DEB_W'(1);
          end
        end
        CONFIRM: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              state_d     = HELD;
              key_d       = cand_q;
              key_valid_d = 1'b1;
              key_press_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
`endif
            end
          end else if (single) begin
            cand_d = acc_code_d;
            cnt_d  = DEB_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (match) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if ((!rep_first_q && rep_inc == REP_DELAY) ||
                ( rep_first_q && rep_inc == REP_RATE)) begin
              key_press_d = 1'b1;
              rep_cnt_d   = '0;
              rep_first_d = 1'b1;
            end else begin
              rep_cnt_d = rep_inc;
            end
`endif
          end else begin
            state_d = RELEASE;
            cnt_d   = DEB_W'(1);
          end
        end
        RELEASE: begin
          // Returning to HELD keeps the key and emits no new press.
          if (match) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              state_d     = IDLE;
              key_valid_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, candidate, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_press_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_press_q <= key_press_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (one scan = 16 clocks). A contact matrix models the keypad: a closed
// contact at (r,c) pulls row r low while column c is driven low.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_CLKS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] contact [4];   // contact[r][c] = 1 -> key at row r, col c closed
  logic [3:0] row_model;
  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_DELAY_SCANS(4)
    , .REPEAT_RATE_SCANS(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row_model[r] = ~|(contact[r] & ~kp_if.col);
  end
  assign kp_if.row = row_model;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_contacts();
    for (int r = 0; r < 4; r++) contact[r] = 4'b0000;
  endtask

  // Leaves the bench on the falling edge where rst was released; scan s
  // then completes on the 16*s-th following falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_scan(output int presses, output logic press_last,
                          output logic valid_last);
    presses    = 0;
    press_last = 1'b0;
    valid_last = 1'b0;
    for (int i = 0; i < SCAN_CLKS; i++) begin
      @(negedge clk);
      if (kp_if.key_press === 1'b1) presses++;
      press_last = kp_if.key_press;
      valid_last = kp_if.key_valid;
    end
  endtask

  task automatic test_reset();
    logic [3:0] col_seq [5];
    int p; logic pl, vl;
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    clear_contacts();
    apply_reset();
    contact[2][1] = 1'b1;
    for (int s = 0; s < 3; s++) run_scan(p, pl, vl);
    n_checks++;
    if (vl !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_hold_valid: got %b want 1", vl);
    end
    // Asynchronous reset between clock edges, mid-scan.
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (kp_if.col !== 4'b1110) begin
      n_fail++; $display("FAIL reset_async_col: got %b want 1110", kp_if.col);
    end
    n_checks++;
    if (kp_if.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_valid: got %b want 0", kp_if.key_valid);
    end
    n_checks++;
    if (kp_if.key_press !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_press: got %b want 0", kp_if.key_press);
    end
    n_checks++;
    if (kp_if.key !== 4'h0) begin
      n_fail++; $display("FAIL reset_async_key: got %h want 0", kp_if.key);
    end
    clear_contacts();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) repeat (4) @(negedge clk);
      n_checks++;
      if (kp_if.col !== col_seq[k]) begin
        n_fail++;
        $display("FAIL reset_col_seq[%0d]: got %b want %b", k, kp_if.col, col_seq[k]);
      end
      n_checks++;
      if (kp_if.key_press !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_press[%0d]: got %b want 0", k, kp_if.key_press);
      end
    end
  endtask

  task automatic test_single_press();
    int p; logic pl, vl;
    clear_contacts();
    apply_reset();
    contact[2][1] = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      run_scan(p, pl, vl);
      n_checks++;
      if (p !== ((s == 3) ? 1 : 0)) begin
        n_fail++; $display("FAIL single_presses[scan %0d]: got %0d want %0d", s, p, (s == 3) ? 1 : 0);
      end
      n_checks++;
      if (vl !== (s >= 3)) begin
        n_fail++; $display("FAIL single_valid[scan %0d]: got %b want %b", s, vl, s >= 3);
      end
      if (s == 3) begin
        n_checks++;
        if (pl !== 1'b1) begin
          n_fail++; $display("FAIL single_press_timing: last-cycle press %b want 1", pl);
        end
        n_checks++;
        if (kp_if.key !== 4'h9) begin
          n_fail++; $display("FAIL single_key: got %h want 9", kp_if.key);
        end
      end
    end
  endtask

  // Continues from test_single_press with key 9 held.
  task automatic test_release();
    logic closed [6];
    logic exp_valid [6];
    int p, total; logic pl, vl;
    closed    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    total = 0;
    for (int s = 0; s < 6; s++) begin
      contact[2][1] = closed[s];
      run_scan(p, pl, vl);
      total += p;
      n_checks++;
      if (vl !== exp_valid[s]) begin
        n_fail++; $display("FAIL release_valid[scan %0d]: got %b want %b", s, vl, exp_valid[s]);
      end
    end
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL release_presses: got %0d want 0", total);
    end
    n_checks++;
    if (kp_if.key !== 4'h9) begin
      n_fail++; $display("FAIL release_key_hold: got %h want 9", kp_if.key);
    end
  endtask

  task automatic test_bounce();
    int p, total; logic pl, vl;
    clear_contacts();
    apply_reset();
    total = 0;
    for (int s = 0; s < 10; s++) begin
      contact[2][1] = (s % 2 == 0);
      run_scan(p, pl, vl);
      total += p;
      n_checks++;
      if (vl !== 1'b0) begin
        n_fail++; $display("FAIL bounce_valid[scan %0d]: got %b want 0", s, vl);
      end
    end
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL bounce_presses: got %0d want 0", total);
    end
  endtask

  task automatic test_ghost();
    int p, total; logic pl, vl;
    clear_contacts();
    apply_reset();
    contact[0][0] = 1'b1;
    contact[1][1] = 1'b1;
    total = 0;
    for (int s = 0; s < 5; s++) begin
      run_scan(p, pl, vl);
      total += p;
    end
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL ghost_presses: got %0d want 0", total);
    end
    n_checks++;
    if (vl !== 1'b0) begin
      n_fail++; $display("FAIL ghost_valid: got %b want 0", vl);
    end
    clear_contacts();
    contact[3][3] = 1'b1;
    total = 0;
    for (int s = 0; s < 3; s++) begin
      run_scan(p, pl, vl);
      total += p;
    end
    n_checks++;
    if (total !== 1 || pl !== 1'b1) begin
      n_fail++; $display("FAIL ghost_single_press: got %0d (last %b) want 1 (last 1)", total, pl);
    end
    n_checks++;
    if (kp_if.key !== 4'hF || vl !== 1'b1) begin
      n_fail++; $display("FAIL ghost_single_key: got %h/%b want f/1", kp_if.key, vl);
    end
  endtask

  task automatic test_autorepeat();
    int p, exp_p; logic pl, vl;
    clear_contacts();
    apply_reset();
    contact[1][2] = 1'b1;
    for (int s = 0; s < 3; s++) run_scan(p, pl, vl);
    n_checks++;
    if (pl !== 1'b1 || kp_if.key !== 4'h6) begin
      n_fail++; $display("FAIL repeat_accept: press %b key %h want 1/6", pl, kp_if.key);
    end
    for (int k = 1; k <= 12; k++) begin
      run_scan(p, pl, vl);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_p = (k >= 4 && k % 2 == 0) ? 1 : 0;
`else
      exp_p = 0;
`endif
      n_checks++;
      if (p !== exp_p || pl !== (exp_p == 1)) begin
        n_fail++;
        $display("FAIL repeat_press[+%0d]: got %0d (last %b) want %0d", k, p, pl, exp_p);
      end
    end
    n_checks++;
    if (vl !== 1'b1) begin
      n_fail++; $display("FAIL repeat_valid: got %b want 1", vl);
    end
  endtask

  initial begin
    clear_contacts();
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_ghost();
    test_autorepeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
